imem_uart_loader: RTL and testbench

- Boot-time controller that sequences instruction-memory loading from the UART byte stream.
- Sits between the UART receiver (byte + valid strobe) and the instruction memory write port.
- Assembles little-endian 32-bit words and writes them to consecutive word addresses from 0.
- Holds the RISC-V core in reset until NUM_WORDS words are written, then releases it.

---
 rtl/imem_uart_loader_pkg.sv | 14 +
 rtl/imem_uart_loader_byte_word_packer.sv | 45 ++++
 rtl/imem_uart_loader.sv | 125 ++++++++++++
 tb/tb_imem_uart_loader.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_uart_loader_pkg.sv
// Shared types and constants for the UART boot loader path.
package imem_loader_pkg;

  typedef enum logic [0:0] {
    LOAD = 1'b0,
    RUN  = 1'b1
  } loader_state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int IDX_W          = $clog2(BYTES_PER_WORD);
  // 115200 baud at 100 MHz; consumed by the UART receiver.
  localparam int CLKS_PER_BIT   = 868;

endpackage

// File: rtl/imem_uart_loader_byte_word_packer.sv
// Packs a byte stream into little-endian 32-bit words and flags the completing byte.
module byte_word_packer
  import imem_loader_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic [IDX_W-1:0] byte_idx,
  output logic             word_ready,
  output logic [31:0]      word_data
);

  logic [7:0] lane_reg [BYTES_PER_WORD];

  assign word_ready = byte_valid && !clr && (byte_idx == IDX_W'(BYTES_PER_WORD - 1));

  generate
    for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
      // The completing byte bypasses its lane so the word is ready in the strobe cycle.
      assign word_data[gi*8 +: 8] =
        (byte_valid && byte_idx == IDX_W'(gi)) ? byte_data : lane_reg[gi];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          lane_reg[gi] <= 8'h00;
        end else if (byte_valid && !clr && byte_idx == IDX_W'(gi)) begin
          lane_reg[gi] <= byte_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx <= '0;
    end else if (clr) begin
      byte_idx <= '0;
    end else if (byte_valid) begin
      byte_idx <= byte_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/imem_uart_loader.sv
// Loads NUM_WORDS UART words into imem, then releases the core from reset.
// Optional inter-byte timeout: define IMEM_LOADER_TIMEOUT_EN.
module imem_uart_loader
  import imem_loader_pkg::*;
#(
  parameter int NUM_WORDS      = 64,
  parameter int ADDR_W         = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst_n,
  output logic              loading,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

  loader_state_t     state;
  logic [ADDR_W-1:0] word_cnt;
  logic              reload_prev;
  logic              in_load;
  logic              reload_rise;
  logic              timeout_hit;
  logic [IDX_W-1:0]  byte_idx;
  logic              word_ready;
  logic [31:0]       word_data;

  assign in_load     = (state == LOAD);
  assign reload_rise = reload && !reload_prev;

  byte_word_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (!in_load || timeout_hit),
    .byte_valid (rx_valid && in_load),
    .byte_data  (rx_data),
    .byte_idx   (byte_idx),
    .word_ready (word_ready),
    .word_data  (word_data)
  );

`ifdef IMEM_LOADER_TIMEOUT_EN
  localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [GAP_W-1:0] gap_cnt;
  logic             gap_active;

  // Only an image already in progress can time out.
  assign gap_active  = in_load && (byte_idx != '0 || word_cnt != '0);
  assign timeout_hit = gap_active && !rx_valid && (gap_cnt == GAP_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt <= '0;
      err     <= 1'b0;
    end else begin
      if (!gap_active || rx_valid || timeout_hit) gap_cnt <= '0;
      else                                       gap_cnt <= gap_cnt + GAP_W'(1);

      if (timeout_hit)                  err <= 1'b1;
      else if (in_load && rx_valid)     err <= 1'b0;
      else if (!in_load && reload_rise) err <= 1'b0;
    end
  end
`else
  logic unused_timeout;

  assign timeout_hit    = 1'b0;
  assign err            = 1'b0;
  assign unused_timeout = &{1'b0, byte_idx, (TIMEOUT_CYCLES != 0)};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= LOAD;
      word_cnt    <= '0;
      reload_prev <= 1'b0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= 32'h0;
      cpu_rst_n   <= 1'b0;
      loading     <= 1'b1;
      done        <= 1'b0;
    end else begin
      reload_prev <= reload;
      imem_we     <= 1'b0;
      case (state)
        LOAD: begin
          if (imem_we && imem_addr == LAST_ADDR) begin
            state     <= RUN;
            cpu_rst_n <= 1'b1;
            loading   <= 1'b0;
            done      <= 1'b1;
          end else if (timeout_hit) begin
            word_cnt <= '0;
          end else if (word_ready) begin
            imem_we    <= 1'b1;
            imem_addr  <= word_cnt;
            imem_wdata <= word_data;
            if (word_cnt != LAST_ADDR) word_cnt <= word_cnt + ADDR_W'(1);
          end
        end
        RUN: begin
          if (reload_rise) begin
            state     <= LOAD;
            word_cnt  <= '0;
            cpu_rst_n <= 1'b0;
            loading   <= 1'b1;
            done      <= 1'b0;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Randomized scoreboard bench for imem_uart_loader against a byte-stream image model.
`timescale 1ns/1ps
module tb_imem_uart_loader;

  localparam int NUM_WORDS = 64;
  localparam int ADDR_W    = 6;
  localparam int TIMEOUT   = 1000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              reload = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst_n, loading, done, err;

  always #5 clk = ~clk;

  imem_uart_loader #(
    .NUM_WORDS      (NUM_WORDS),
    .ADDR_W         (ADDR_W),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .reload     (reload),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst_n  (cpu_rst_n),
    .loading    (loading),
    .done       (done),
    .err        (err)
  );

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_w;
  logic [7:0]  buf_q[$];
  logic [31:0] img [NUM_WORDS];
  int          total = 0, bad = 0, cyc = 0, wr_count = 0;
  int          m_cnt = 0;
  bit          m_run = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  // Reference: every 4 accepted bytes form one word at the next address; image full -> RUN.
  task automatic model_byte(input logic [7:0] b, input int k);
    wr_t w;
    if (m_run) return;
    buf_q.push_back(b);
    if (buf_q.size() == 4) begin
      w.addr = m_cnt;
      w.data = {buf_q[3], buf_q[2], buf_q[1], buf_q[0]};
      w.cyc  = k;
      exp_q.push_back(w);
      buf_q.delete();
      m_cnt++;
      if (m_cnt == NUM_WORDS) m_run = 1'b1;
    end
  endtask

  task automatic model_restart();
    m_run = 1'b0;
    m_cnt = 0;
    buf_q.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    model_byte(b, cyc);
    repeat (gap) tick();
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_we"}, imem_we, 0);
    chk({tag, "_addr"}, imem_addr, 0);
    chk({tag, "_wdata"}, imem_wdata, 0);
    chk({tag, "_cpu_rst_n"}, cpu_rst_n, 0);
    chk({tag, "_loading"}, loading, 1);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  // Sends img[start..] with random gaps; the final byte checks the hand-off timing.
  task automatic load_image(input int start);
    for (int w = start; w < NUM_WORDS; w++) begin
      for (int i = 0; i < 4; i++) begin
        if (w == NUM_WORDS - 1 && i == 3) begin
          send(img[w][8*i +: 8], 0);
          chk("last_write_we", imem_we, 1);
          chk("last_write_done", done, 0);
          chk("last_write_cpu_rst_n", cpu_rst_n, 0);
          tick();
          chk("run_done", done, 1);
          chk("run_cpu_rst_n", cpu_rst_n, 1);
          chk("run_loading", loading, 0);
          chk("run_we", imem_we, 0);
        end else begin
          send(img[w][8*i +: 8], $urandom_range(0, 3));
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_count++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, required no write",
                 imem_addr, imem_wdata);
      end else begin
        mon_w = exp_q.pop_front();
        if (imem_addr !== mon_w.addr[ADDR_W-1:0] || imem_wdata !== mon_w.data ||
            cyc != mon_w.cyc || cpu_rst_n !== 1'b0) begin
          bad++;
          $display("FAIL write: got addr=%0d data=%h cyc=%0d cpu_rst_n=%b required addr=%0d data=%h cyc=%0d cpu_rst_n=0",
                   imem_addr, imem_wdata, cyc, cpu_rst_n, mon_w.addr, mon_w.data, mon_w.cyc);
        end else begin
          $display("write addr=%0d data=%h cyc=%0d", imem_addr, imem_wdata, cyc);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset("por");
    rst_n = 1'b1;
    tick();

    img[0] = 32'h003100B3;
    img[1] = 32'h00200093;
    for (int w = 2; w < NUM_WORDS; w++) img[w] = 32'h00000013;
    wr_count = 0;
    for (int i = 0; i < 4; i++) send(img[0][8*i +: 8], 1);
    chk("word0_cpu_rst_n", cpu_rst_n, 0);
    chk("word0_loading", loading, 1);
    // Eight strobes on consecutive cycles spanning two words.
    for (int w = 1; w < 3; w++)
      for (int i = 0; i < 4; i++) send(img[w][8*i +: 8], 0);
    load_image(3);
    chk("image1_write_count", wr_count, NUM_WORDS);

    for (int i = 0; i < 5; i++) send(8'($urandom), 0);
    repeat (2) tick();
    chk("run_ignores_bytes_done", done, 1);

    // Reload edge together with a byte: the byte must not count.
    rx_data  = 8'($urandom);
    rx_valid = 1'b1;
    reload   = 1'b1;
    tick();
    rx_valid = 1'b0;
    model_restart();
    chk("reload_cpu_rst_n", cpu_rst_n, 0);
    chk("reload_loading", loading, 1);
    chk("reload_done", done, 0);

    for (int w = 0; w < NUM_WORDS; w++) img[w] = $urandom;
    wr_count = 0;
    send(img[0][7:0], 1);
    send(img[0][15:8], 1);
    reload = 1'b0;
    tick();
    reload = 1'b1;
    tick();
    send(img[0][23:16], 0);
    send(img[0][31:24], 2);
    load_image(1);
    chk("image2_write_count", wr_count, NUM_WORDS);

    reload = 1'b0;
    tick();
    reload = 1'b1;
    tick();
    model_restart();
    for (int i = 0; i < 130; i++) send(8'($urandom), $urandom_range(0, 2));
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    model_restart();
    check_reset("mid_reset");
    chk("mid_reset_pending", exp_q.size(), 0);
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) send(8'($urandom), 1);
    repeat (3) tick();

`ifdef IMEM_LOADER_TIMEOUT_EN
    send(8'($urandom), 0);
    send(8'($urandom), 0);
    repeat (TIMEOUT - 1) tick();
    chk("timeout_pre_err", err, 0);
    tick();
    chk("timeout_err", err, 1);
    chk("timeout_no_write", imem_we, 0);
    model_restart();
    send(8'($urandom), 1);
    chk("timeout_err_cleared", err, 0);
    for (int i = 0; i < 3; i++) send(8'($urandom), 1);
    repeat (3) tick();
`endif

    repeat (5) tick();
    chk("final_pending_writes", exp_q.size(), 0);
    chk("final_err", err, 0);
    chk("final_loading", loading, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
